sda_kernel_run_ctrl: RTL and testbench

// Kernel run/status controller between the wrapper control-register port and the action go/done

---
 rtl/sda_kernel_run_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sda_kernel_run_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sda_kernel_run_ctrl.sv
// Kernel run/status controller: ap_ctrl register map, GIE/IER/ISR interrupt registers and the
// go/done sequencing of single or auto-restarting action runs.
module sda_kernel_run_ctrl #(
    parameter int REG_ADDR_WIDTH = 2,
    parameter int IRQ_ENABLE     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reg_req,
    output logic                      reg_ack,
    input  logic                      reg_write_en,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]               reg_wdata,
    output logic [31:0]               reg_rdata,
    output logic                      action_go_valid,
    input  logic                      action_go_holdoff,
    input  logic                      action_done_valid,
    output logic                      action_done_stop,
    output logic                      interrupt
);
    // state     | meaning
    // ST_IDLE   | no run in progress; idle bit reads 1
    // ST_LAUNCH | go_valid asserted, waiting for the action to accept
    // ST_RUN    | action running; done accepted (done_stop low)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic IRQ_ON = (IRQ_ENABLE != 0);

    state_t      state_q, state_d;
    logic        usr_start_q, usr_start_d;
    logic        rearm_q, rearm_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        auto_q, auto_d;
    logic        gie_q, gie_d;
    logic [1:0]  ier_q, ier_d;
    logic [1:0]  isr_q, isr_d;
    logic        irq_q, irq_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        go_valid_q, go_valid_d;
    logic        done_stop_q, done_stop_d;

    logic        acc, wr_en, rd_en, go_xfer, done_xfer, start_bit;
    logic [31:0] addr_w;
    logic [31:0] ap_ctrl;
    logic        unused_wdata;

    assign unused_wdata = ^{reg_wdata[31:8], reg_wdata[6:2]};

    always_comb begin
        addr_w    = 32'(reg_addr);
        acc       = reg_req & ~ack_q;
        wr_en     = acc & reg_write_en;
        rd_en     = acc & ~reg_write_en;
        go_xfer   = go_valid_q & ~action_go_holdoff;
        done_xfer = action_done_valid & ~done_stop_q;
        // start as seen by software: a user-written start or the auto-restart re-arm
        start_bit = usr_start_q | rearm_q;
        ap_ctrl   = {24'd0, auto_q, 3'd0, ready_q, state_q == ST_IDLE, done_q, start_bit};

        state_d     = state_q;
        usr_start_d = usr_start_q;
        rearm_d     = rearm_q;
        done_d      = done_q;
        ready_d     = ready_q;
        auto_d      = auto_q;
        gie_d       = gie_q;
        ier_d       = ier_q;
        isr_d       = isr_q;

        if (rd_en && addr_w == 32'd0) begin
            done_d  = 1'b0;
            ready_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_bit) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (go_xfer) begin
                    ready_d     = 1'b1;
                    usr_start_d = 1'b0;
                    rearm_d     = auto_q;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (done_xfer) begin
                    done_d  = 1'b1;
                    state_d = start_bit ? ST_LAUNCH : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // register writes follow the FSM so a coinciding start write is not lost
        if (wr_en) begin
            case (addr_w)
                32'd0: begin
                    if (reg_wdata[0]) usr_start_d = 1'b1;
                    auto_d = reg_wdata[7];
                    if (!reg_wdata[7]) rearm_d = 1'b0;
                end
                32'd1:   gie_d = reg_wdata[0];
                32'd2:   ier_d = reg_wdata[1:0];
                32'd3:   isr_d = isr_q ^ reg_wdata[1:0];
                default: ;
            endcase
        end

        isr_d = isr_d | {go_xfer & ier_q[1], done_xfer & ier_q[0]};

        if (!IRQ_ON) begin
            gie_d = 1'b0;
            ier_d = 2'd0;
            isr_d = 2'd0;
        end

        irq_d       = gie_q & |(isr_q & ier_q);
        go_valid_d  = (state_d == ST_LAUNCH);
        done_stop_d = (state_d != ST_RUN);
        ack_d       = acc;

        rdata_d = 32'd0;
        if (rd_en) begin
            case (addr_w)
                32'd0:   rdata_d = ap_ctrl;
                32'd1:   rdata_d = {31'd0, gie_q};
                32'd2:   rdata_d = {30'd0, ier_q};
                32'd3:   rdata_d = {30'd0, isr_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            usr_start_q <= 1'b0;
            rearm_q     <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            auto_q      <= 1'b0;
            gie_q       <= 1'b0;
            ier_q       <= 2'd0;
            isr_q       <= 2'd0;
            irq_q       <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= 32'd0;
            go_valid_q  <= 1'b0;
            done_stop_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            usr_start_q <= usr_start_d;
            rearm_q     <= rearm_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            auto_q      <= auto_d;
            gie_q       <= gie_d;
            ier_q       <= ier_d;
            isr_q       <= isr_d;
            irq_q       <= irq_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            go_valid_q  <= go_valid_d;
            done_stop_q <= done_stop_d;
        end
    end

    assign reg_ack          = ack_q;
    assign reg_rdata        = rdata_q;
    assign action_go_valid  = go_valid_q;
    assign action_done_stop = done_stop_q;
    assign interrupt        = irq_q;

endmodule

// File: tb/tb_sda_kernel_run_ctrl.sv
// Directed scenarios with randomized run lengths, holdoffs and register data, checked against
// expectations derived from the ap_ctrl/interrupt rules and a small register model.
module tb_sda_kernel_run_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        reg_req, reg_ack, reg_write_en;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        action_go_valid, action_go_holdoff, action_done_valid, action_done_stop;
    logic        interrupt;

    int checks = 0;
    int errors = 0;

    int hold_left = 0, run_len = 5, run_left = 0;
    int go_cnt = 0, done_cnt = 0, gv_cycles = 0, cyc = 0;
    int done_cyc = -1, irq_rise_cyc = -1;
    bit done_fire = 1'b0, irq_prev = 1'b0;

    sda_kernel_run_ctrl #(.REG_ADDR_WIDTH(2), .IRQ_ENABLE(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .reg_req           (reg_req),
        .reg_ack           (reg_ack),
        .reg_write_en      (reg_write_en),
        .reg_addr          (reg_addr),
        .reg_wdata         (reg_wdata),
        .reg_rdata         (reg_rdata),
        .action_go_valid   (action_go_valid),
        .action_go_holdoff (action_go_holdoff),
        .action_done_valid (action_done_valid),
        .action_done_stop  (action_done_stop),
        .interrupt         (interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Action model: decisions made at negedge take effect at the following posedge.
    initial begin
        action_go_holdoff = 1'b0;
        action_done_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                hold_left = 0; run_left = 0; done_fire = 1'b0; irq_prev = 1'b0;
                action_done_valid = 1'b0; action_go_holdoff = 1'b0;
                continue;
            end
            if (done_fire) begin
                action_done_valid = 1'b0;
                done_fire = 1'b0;
            end
            action_go_holdoff = (hold_left > 0);
            if (action_go_valid) begin
                gv_cycles++;
                if (hold_left > 0) hold_left--;
                else begin
                    go_cnt++;
                    run_left = run_len;
                end
            end
            if (run_left > 0) begin
                run_left--;
                if (run_left == 0) action_done_valid = 1'b1;
            end
            if (action_done_valid && !action_done_stop) begin
                done_fire = 1'b1;
                done_cnt++;
                done_cyc = cyc;
            end
            if (interrupt && !irq_prev) irq_rise_cyc = cyc;
            irq_prev = interrupt;
        end
    end

    task automatic reg_xfer(input bit we, input logic [1:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd);
        int n = 0;
        reg_req = 1'b1; reg_write_en = we; reg_addr = addr; reg_wdata = wd;
        do begin
            tick();
            n++;
        end while (!reg_ack && n < 10);
        check("reg_ack", 32'(reg_ack), 32'd1);
        rd = reg_rdata;
        reg_req = 1'b0; reg_write_en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        reg_xfer(1'b1, addr, wd, dummy);
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] val);
        reg_xfer(1'b0, addr, 32'd0, val);
    endtask

    task automatic wait_go(input int target);
        int n = 0;
        while (go_cnt < target && n < 400) begin tick(); n++; end
        check("wait_go", 32'(go_cnt >= target), 32'd1);
        tick();
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 400) begin tick(); n++; end
        check("wait_done", 32'(done_cnt >= target), 32'd1);
        tick();
    endtask

    task automatic wait_fire();
        int n = 0;
        do begin tick(); n++; end while (!done_fire && n < 400);
        check("wait_fire", 32'(done_fire), 32'd1);
    endtask

    initial begin
        logic [31:0] r, d;
        logic [1:0]  a, isr_m, ier_m;
        logic        gie_m;
        int          g0, d0, hold, nrest;

        reset = 1'b0; reg_req = 1'b0; reg_write_en = 1'b0; reg_addr = 2'd0; reg_wdata = 32'd0;
        #1 reset = 1'b1;
        #1;
        check("rst_go_valid", 32'(action_go_valid), 32'd0);
        check("rst_done_stop", 32'(action_done_stop), 32'd1);
        check("rst_ack", 32'(reg_ack), 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        check("rst_irq", 32'(interrupt), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        rd(2'd0, r); check("rst_ap_ctrl", r, 32'h04);

        // single run
        run_len = $urandom_range(4, 12); hold_left = 0;
        g0 = go_cnt; d0 = done_cnt; gv_cycles = 0;
        wr(2'd0, 32'h1);
        check("sr_go_at_ack", 32'(action_go_valid), 32'd0);
        tick();
        check("sr_go_latency", 32'(action_go_valid), 32'd1);
        wait_done(d0 + 1);
        check("sr_go_cycles", gv_cycles, 32'd1);
        check("sr_go_count", go_cnt - g0, 32'd1);
        rd(2'd0, r); check("sr_read1", r, 32'h0E);
        rd(2'd0, r); check("sr_read2", r, 32'h04);

        // holdoff
        hold = $urandom_range(1, 6); hold_left = hold; run_len = $urandom_range(6, 12);
        g0 = go_cnt; d0 = done_cnt; gv_cycles = 0;
        wr(2'd0, 32'h1);
        rd(2'd0, r); check("ho_launch_read", r, 32'h01);
        wait_go(g0 + 1);
        check("ho_go_cycles", gv_cycles, hold + 1);
        check("ho_go_low", 32'(action_go_valid), 32'd0);
        rd(2'd0, r); check("ho_run_read", r, 32'h08);
        wait_done(d0 + 1);
        rd(2'd0, r); check("ho_done_read", r, 32'h06);
        rd(2'd0, r); check("ho_idle_read", r, 32'h04);

        // auto-restart
        nrest = $urandom_range(2, 4); run_len = $urandom_range(5, 10); hold_left = 0;
        g0 = go_cnt; d0 = done_cnt;
        wr(2'd0, 32'h81);
        wait_done(d0 + nrest);
        wait_go(g0 + nrest + 1);
        wr(2'd0, 32'h0);
        wait_done(d0 + nrest + 1);
        repeat (20) tick();
        check("ar_go_count", go_cnt - g0, nrest + 1);
        check("ar_go_low", 32'(action_go_valid), 32'd0);
        rd(2'd0, r); check("ar_final_read", r, 32'h0E);

        // interrupt timing on done
        wr(2'd1, 32'h1); wr(2'd2, 32'h1);
        rd(2'd3, r); check("irq_isr_init", r, 32'h0);
        run_len = $urandom_range(4, 10); d0 = done_cnt; irq_rise_cyc = -1;
        wr(2'd0, 32'h1);
        wait_done(d0 + 1);
        repeat (3) tick();
        check("irq_latency", irq_rise_cyc - done_cyc, 32'd2);
        check("irq_level", 32'(interrupt), 32'd1);
        rd(2'd3, r); check("irq_isr_set", r, 32'h1);
        wr(2'd3, 32'h1);
        rd(2'd3, r); check("irq_isr_clr", r, 32'h0);
        check("irq_cleared", 32'(interrupt), 32'd0);

        // random register traffic against a register model
        gie_m = 1'b1; ier_m = 2'd1; isr_m = 2'd0;
        for (int i = 0; i < 8; i++) begin
            a = 2'($urandom_range(1, 3));
            d = $urandom;
            wr(a, d);
            case (a)
                2'd1: gie_m = d[0];
                2'd2: ier_m = d[1:0];
                default: isr_m = isr_m ^ d[1:0];
            endcase
            rd(a, r);
            case (a)
                2'd1: check("rnd_gie", r, {31'd0, gie_m});
                2'd2: check("rnd_ier", r, {30'd0, ier_m});
                default: check("rnd_isr", r, {30'd0, isr_m});
            endcase
        end
        tick(); tick();
        check("rnd_irq", 32'(interrupt), 32'(gie_m & |(isr_m & ier_m)));

        // ISR set by go and done per IER, interrupt gated by GIE
        wr(2'd3, {30'd0, isr_m});
        ier_m = 2'($urandom_range(1, 3));
        wr(2'd2, {30'd0, ier_m}); wr(2'd1, 32'h0);
        run_len = $urandom_range(4, 10); d0 = done_cnt;
        wr(2'd0, 32'h1);
        wait_done(d0 + 1);
        rd(2'd3, r); check("ier_isr", r, {30'd0, ier_m});
        check("gie_off_irq", 32'(interrupt), 32'd0);
        wr(2'd1, 32'h1);
        tick(); tick();
        check("gie_on_irq", 32'(interrupt), 32'd1);

        // clear-on-read racing a done transfer
        wr(2'd2, 32'h1); wr(2'd3, {30'd0, ier_m});
        rd(2'd0, r);
        run_len = $urandom_range(6, 10);
        wr(2'd0, 32'h1);
        wait_fire();
        rd(2'd0, r); check("race_read_done", 32'(r[1]), 32'd0);
        rd(2'd0, r); check("race_next_done", 32'(r[1]), 32'd1);
        rd(2'd3, r); check("race_isr_pre", r, 32'h1);

        // ISR toggle racing a done set
        wr(2'd0, 32'h1);
        wait_fire();
        wr(2'd3, 32'h1);
        rd(2'd3, r); check("race_isr_set_wins", 32'(r[0]), 32'd1);
        wr(2'd3, 32'h1);

        // other AP_CTRL bits ignored, b0=0 does not start
        repeat (3) tick();
        rd(2'd0, r);
        g0 = go_cnt;
        wr(2'd0, 32'h7E);
        repeat (5) tick();
        check("ign_no_go", go_cnt - g0, 32'd0);
        rd(2'd0, r); check("ign_read", r, 32'h04);

        // reset in RUN with a pending start
        run_len = 40; g0 = go_cnt;
        wr(2'd0, 32'h1);
        wait_go(g0 + 1);
        wr(2'd0, 32'h1);
        check("rr_in_run", 32'(action_done_stop), 32'd0);
        reset = 1'b1;
        #1;
        check("rr_done_stop", 32'(action_done_stop), 32'd1);
        check("rr_go_valid", 32'(action_go_valid), 32'd0);
        check("rr_irq", 32'(interrupt), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        g0 = go_cnt;
        tick();
        rd(2'd0, r); check("rr_ap_ctrl", r, 32'h04);
        repeat (20) tick();
        check("rr_no_relaunch", go_cnt - g0, 32'd0);
        check("rr_go_low", 32'(action_go_valid), 32'd0);
        rd(2'd3, r); check("rr_isr", r, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
